// File: rtl/wb_arbiter_pkg.sv
//------------------------------------------------------------------
// wb_arbiter_pkg : round-robin index helpers for the bus arbiter
// Revision 1.0
//------------------------------------------------------------------
`default_nettype none

package wb_arbiter_pkg;

  // Index following idx in a ring of count entries.
  function automatic int rr_next(input int idx, input int count);
    return (idx + 1 >= count) ? 0 : idx + 1;
  endfunction

  function automatic int rr_wrap(input int base, input int off, input int count);
    int sum;
    sum = base + off;
    return (sum >= count) ? sum - count : sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_pick.sv
//------------------------------------------------------------------
// rr_priority_pick : first set request at or after a start index
// Revision 1.0
//------------------------------------------------------------------
`default_nettype none

module rr_priority_pick
  import wb_arbiter_pkg::*;
#(
  parameter  int Count      = 2,
  localparam int GrantWidth = $clog2(Count)
) (
  input  logic [Count-1:0]      req_i,
  input  logic [GrantWidth-1:0] start_i,
  output logic                  valid_o,
  output logic [GrantWidth-1:0] idx_o
);

  logic [2*Count-1:0] req_dbl;
  logic [2*Count-1:0] req_rot;

  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl >> start_i;

  // Scan from the far end so the nearest requester is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int off = Count - 1; off >= 0; off--) begin
      if (req_rot[off]) begin
        valid_o = 1'b1;
        idx_o   = GrantWidth'(rr_wrap(int'(start_i), off, Count));
      end
    end
  end

  logic unused_hi;
  assign unused_hi = ^req_rot[2*Count-1:Count];

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
//------------------------------------------------------------------
// wb_arbiter : round-robin Wishbone B4 pipelined bus arbiter
// Revision 1.0
//------------------------------------------------------------------
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter  int Count          = 2,
  parameter  int DataWidth      = 32,
  parameter  int AddrWidth      = 30,
  parameter  int MaxOutstanding = 4,
  localparam int SelWidth       = DataWidth / 8,
  localparam int GrantWidth     = $clog2(Count)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,

  input  logic [DataWidth-1:0] wb_m_data_i  [Count],
  input  logic [AddrWidth-1:0] wb_m_addr_i  [Count],
  input  logic [SelWidth-1:0]  wb_m_sel_i   [Count],
  input  logic                 wb_m_we_i    [Count],
  input  logic                 wb_m_cyc_i   [Count],
  input  logic                 wb_m_stb_i   [Count],
  output logic [DataWidth-1:0] wb_m_data_o  [Count],
  output logic                 wb_m_ack_o   [Count],
  output logic                 wb_m_err_o   [Count],
  output logic                 wb_m_stall_o [Count],

  output logic [DataWidth-1:0] wb_s_data_o,
  output logic [AddrWidth-1:0] wb_s_addr_o,
  output logic [SelWidth-1:0]  wb_s_sel_o,
  output logic                 wb_s_we_o,
  output logic                 wb_s_cyc_o,
  output logic                 wb_s_stb_o,
  input  logic [DataWidth-1:0] wb_s_data_i,
  input  logic                 wb_s_ack_i,
  input  logic                 wb_s_err_i,
  input  logic                 wb_s_stall_i
);

  localparam int                    CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0]   CntMax   = CntWidth'(MaxOutstanding);
  localparam logic [GrantWidth-1:0] LastInit = GrantWidth'(Count - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [GrantWidth-1:0] grant_q, grant_d;
  logic [GrantWidth-1:0] last_q, last_d;
  logic [CntWidth-1:0]   outstanding_q, outstanding_d;

  logic [Count-1:0]      cyc_vec;
  logic [GrantWidth-1:0] start_idx;
  logic [GrantWidth-1:0] pick_idx;
  logic                  pick_valid;
  logic                  busy;
  logic                  owner_cyc;
  logic                  owner_stall;
  logic                  accept;
  logic                  retire;

  for (genvar i = 0; i < Count; i++) begin : g_cyc_vec
    assign cyc_vec[i] = wb_m_cyc_i[i];
  end

  assign start_idx = GrantWidth'(rr_next(int'(last_q), Count));

  rr_priority_pick #(
    .Count(Count)
  ) u_pick (
    .req_i  (cyc_vec),
    .start_i(start_idx),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  assign busy        = (state_q == BUSY);
  assign owner_cyc   = busy && wb_m_cyc_i[grant_q];
  assign owner_stall = wb_s_stall_i | (outstanding_q == CntMax);

  // Once the owner drops cyc, cyc stays up only to drain in-flight responses.
  assign wb_s_cyc_o  = owner_cyc || (busy && (outstanding_q != '0));
  assign wb_s_stb_o  = owner_cyc && wb_m_stb_i[grant_q];
  assign wb_s_data_o = wb_m_data_i[grant_q];
  assign wb_s_addr_o = wb_m_addr_i[grant_q];
  assign wb_s_sel_o  = wb_m_sel_i[grant_q];
  assign wb_s_we_o   = wb_m_we_i[grant_q];

  assign accept = wb_s_stb_o && !owner_stall;
  assign retire = (wb_s_ack_i || wb_s_err_i) && (outstanding_q != '0);

  for (genvar i = 0; i < Count; i++) begin : g_resp
    logic is_owner;
    assign is_owner        = busy && (grant_q == GrantWidth'(i));
    assign wb_m_data_o[i]  = wb_s_data_i;
    assign wb_m_ack_o[i]   = is_owner && wb_m_cyc_i[i] && wb_s_ack_i;
    assign wb_m_err_o[i]   = is_owner && wb_m_cyc_i[i] && wb_s_err_i;
    assign wb_m_stall_o[i] = is_owner ? owner_stall : 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    outstanding_d = outstanding_q;

    if (accept && !retire) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (retire && !accept) begin
      outstanding_d = outstanding_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = pick_idx;
          last_d  = pick_idx;
        end
      end
      BUSY: begin
        if (!wb_m_cyc_i[grant_q] && (outstanding_q == '0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_q        <= LastInit;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
//------------------------------------------------------------------
// tb_wb_arbiter : directed self-checking bench for wb_arbiter
// Revision 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int SW = DW / 8;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset_ni = 1'b0;

  logic [DW-1:0] m_data  [N];
  logic [AW-1:0] m_addr  [N];
  logic [SW-1:0] m_sel   [N];
  logic          m_we    [N];
  logic          m_cyc   [N];
  logic          m_stb   [N];
  logic [DW-1:0] m_rdata [N];
  logic          m_ack   [N];
  logic          m_err   [N];
  logic          m_stall [N];

  logic [DW-1:0] s_data_o;
  logic [AW-1:0] s_addr_o;
  logic [SW-1:0] s_sel_o;
  logic          s_we_o;
  logic          s_cyc_o;
  logic          s_stb_o;
  logic [DW-1:0] s_data_i;
  logic          s_ack;
  logic          s_err;
  logic          s_stall;

  wb_arbiter #(
    .Count(N), .DataWidth(DW), .AddrWidth(AW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .wb_m_data_i(m_data), .wb_m_addr_i(m_addr), .wb_m_sel_i(m_sel),
    .wb_m_we_i(m_we), .wb_m_cyc_i(m_cyc), .wb_m_stb_i(m_stb),
    .wb_m_data_o(m_rdata), .wb_m_ack_o(m_ack), .wb_m_err_o(m_err),
    .wb_m_stall_o(m_stall),
    .wb_s_data_o(s_data_o), .wb_s_addr_o(s_addr_o), .wb_s_sel_o(s_sel_o),
    .wb_s_we_o(s_we_o), .wb_s_cyc_o(s_cyc_o), .wb_s_stb_o(s_stb_o),
    .wb_s_data_i(s_data_i), .wb_s_ack_i(s_ack), .wb_s_err_i(s_err),
    .wb_s_stall_i(s_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [N-1:0] cyc, input logic [N-1:0] stb);
    for (int i = 0; i < N; i++) begin
      m_cyc[i] = cyc[i];
      m_stb[i] = stb[i];
    end
  endtask

  function automatic logic [N-1:0] stall_mask();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_stall[i];
    return r;
  endfunction

  function automatic logic [N-1:0] ack_mask();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_ack[i];
    return r;
  endfunction

  function automatic logic [N-1:0] err_mask();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_err[i];
    return r;
  endfunction

  task automatic do_reset();
    #1 reset_ni = 1'b0;
    set_req('0, '0);
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_ni = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  cyc;
    logic [N-1:0]  stb;
    logic          ack;
    logic          err;
    logic          sst;
    logic          e_cyc;
    logic          e_stb;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_stall;
    logic [N-1:0]  e_ack;
    logic [N-1:0]  e_err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int owner;
    int acc;
    int exp_order [5];

    for (int i = 0; i < N; i++) begin
      m_data[i] = 32'hD000_0000 + i;
      m_sel[i]  = SW'(i + 1);
      m_we[i]   = i[0];
    end
    m_addr[0] = 30'h100;
    m_addr[1] = 30'h10;
    m_addr[2] = 30'h200;
    set_req('0, '0);
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_data_i = '0;

    // cyc, stb, ack, err, slave stall | s_cyc, s_stb, addr, stall, ack, err
    vecs[0]  = '{3'b000, 3'b000, 0, 0, 0, 0, 0, 30'h0,   3'b111, 3'b000, 3'b000};
    vecs[1]  = '{3'b010, 3'b010, 0, 0, 0, 0, 0, 30'h0,   3'b111, 3'b000, 3'b000};
    vecs[2]  = '{3'b010, 3'b010, 0, 0, 0, 1, 1, 30'h10,  3'b101, 3'b000, 3'b000};
    vecs[3]  = '{3'b010, 3'b000, 1, 0, 0, 1, 0, 30'h0,   3'b101, 3'b010, 3'b000};
    vecs[4]  = '{3'b000, 3'b000, 0, 0, 0, 0, 0, 30'h0,   3'b101, 3'b000, 3'b000};
    vecs[5]  = '{3'b111, 3'b111, 0, 0, 0, 0, 0, 30'h0,   3'b111, 3'b000, 3'b000};
    vecs[6]  = '{3'b111, 3'b111, 0, 0, 1, 1, 1, 30'h200, 3'b111, 3'b000, 3'b000};
    vecs[7]  = '{3'b111, 3'b111, 0, 0, 0, 1, 1, 30'h200, 3'b011, 3'b000, 3'b000};
    vecs[8]  = '{3'b111, 3'b111, 1, 0, 0, 1, 1, 30'h200, 3'b011, 3'b100, 3'b000};
    vecs[9]  = '{3'b111, 3'b011, 1, 0, 0, 1, 0, 30'h0,   3'b011, 3'b100, 3'b000};
    vecs[10] = '{3'b011, 3'b011, 0, 0, 0, 0, 0, 30'h0,   3'b011, 3'b000, 3'b000};
    vecs[11] = '{3'b011, 3'b011, 0, 0, 0, 0, 0, 30'h0,   3'b111, 3'b000, 3'b000};
    vecs[12] = '{3'b011, 3'b011, 0, 0, 0, 1, 1, 30'h100, 3'b110, 3'b000, 3'b000};
    vecs[13] = '{3'b010, 3'b010, 1, 0, 0, 1, 0, 30'h0,   3'b110, 3'b000, 3'b000};
    vecs[14] = '{3'b010, 3'b010, 0, 0, 0, 0, 0, 30'h0,   3'b110, 3'b000, 3'b000};
    vecs[15] = '{3'b010, 3'b010, 0, 0, 0, 0, 0, 30'h0,   3'b111, 3'b000, 3'b000};
    vecs[16] = '{3'b010, 3'b000, 0, 1, 0, 1, 0, 30'h0,   3'b101, 3'b000, 3'b010};
    vecs[17] = '{3'b000, 3'b000, 0, 0, 0, 0, 0, 30'h0,   3'b101, 3'b000, 3'b000};
    vecs[18] = '{3'b000, 3'b000, 0, 0, 0, 0, 0, 30'h0,   3'b111, 3'b000, 3'b000};

    // Reset state, with a master already requesting
    m_cyc[0] = 1'b1;
    #1;
    chk("reset s_cyc_o", s_cyc_o, 0);
    chk("reset s_stb_o", s_stb_o, 0);
    chk("reset stall", stall_mask(), 3'b111);
    chk("reset ack", ack_mask(), 3'b000);
    m_cyc[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_ni = 1'b1;

    for (int v = 0; v < NV; v++) begin
      tick();
      set_req(vecs[v].cyc, vecs[v].stb);
      s_ack   = vecs[v].ack;
      s_err   = vecs[v].err;
      s_stall = vecs[v].sst;
      #1;
      chk($sformatf("v%0d s_cyc_o", v), s_cyc_o, vecs[v].e_cyc);
      chk($sformatf("v%0d s_stb_o", v), s_stb_o, vecs[v].e_stb);
      chk($sformatf("v%0d stall", v), stall_mask(), vecs[v].e_stall);
      chk($sformatf("v%0d ack", v), ack_mask(), vecs[v].e_ack);
      chk($sformatf("v%0d err", v), err_mask(), vecs[v].e_err);
      if (vecs[v].e_stb) chk($sformatf("v%0d s_addr_o", v), s_addr_o, vecs[v].e_addr);
    end
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;

    s_data_i = 32'hA5A5_0001;
    #1;
    chk("rdata broadcast m2", m_rdata[2], 32'hA5A5_0001);
    chk("rdata broadcast m0", m_rdata[0], 32'hA5A5_0001);

    // Round robin, three masters holding cyc, one transfer per tenure
    do_reset();
    set_req(3'b111, 3'b000);
    exp_order = '{0, 1, 2, 0, 1};
    for (int k = 0; k < 5; k++) begin
      tick();
      owner = -1;
      for (int i = 0; i < N; i++) if (!m_stall[i]) owner = i;
      chk($sformatf("rr%0d owner", k), owner, exp_order[k]);
      if (owner < 0) owner = 0;
      m_stb[owner] = 1'b1;
      #1;
      chk($sformatf("rr%0d s_addr_o", k), s_addr_o, m_addr[owner]);
      chk($sformatf("rr%0d s_data_o", k), s_data_o, m_data[owner]);
      tick();
      m_stb[owner] = 1'b0;
      s_ack = 1'b1;
      #1;
      chk($sformatf("rr%0d ack", k), m_ack[owner], 1);
      tick();
      s_ack = 1'b0;
      m_cyc[owner] = 1'b0;
      #1;
      chk($sformatf("rr%0d release s_cyc_o", k), s_cyc_o, 0);
      tick();
      m_cyc[owner] = 1'b1;
      #1;
      chk($sformatf("rr%0d dead s_cyc_o", k), s_cyc_o, 0);
      chk($sformatf("rr%0d dead stall", k), stall_mask(), 3'b111);
    end
    set_req('0, '0);

    // Outstanding limit with a silent slave, then early cyc drop
    tick();
    set_req(3'b001, 3'b001);
    #1;
    chk("lim arb stall", m_stall[0], 1);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_stb_o && !m_stall[0]) acc++;
    end
    chk("lim accepted", acc, 4);
    chk("lim stall at max", m_stall[0], 1);
    s_ack = 1'b1;
    #1;
    chk("lim ack fwd", m_ack[0], 1);
    chk("lim stall during ack", m_stall[0], 1);
    tick();
    s_ack = 1'b0;
    #1;
    chk("lim one released", m_stall[0], 0);
    chk("lim one released stb", s_stb_o, 1);
    tick();
    chk("lim restall", m_stall[0], 1);
    m_stb[0] = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("drain ack1 fwd", m_ack[0], 1);
    tick();
    chk("drain ack2 fwd", m_ack[0], 1);
    tick();
    m_cyc[0] = 1'b0;
    #1;
    chk("drop s_cyc_o 2 left", s_cyc_o, 1);
    chk("drop ack discarded", m_ack[0], 0);
    chk("drop s_stb_o", s_stb_o, 0);
    tick();
    chk("drop s_cyc_o 1 left", s_cyc_o, 1);
    chk("drop ack2 discarded", m_ack[0], 0);
    tick();
    s_ack = 1'b0;
    #1;
    chk("drop s_cyc_o drained", s_cyc_o, 0);
    tick();
    chk("drop idle stall", stall_mask(), 3'b111);

    // Asynchronous reset in the middle of a tenure
    set_req(3'b001, 3'b000);
    tick();
    chk("mid busy stall0", m_stall[0], 0);
    chk("mid busy s_cyc_o", s_cyc_o, 1);
    m_cyc[1] = 1'b1;
    #1 reset_ni = 1'b0;
    #1;
    chk("mid reset s_cyc_o", s_cyc_o, 0);
    chk("mid reset stall", stall_mask(), 3'b111);
    tick();
    #1 reset_ni = 1'b1;
    tick();
    chk("post reset grant m0", stall_mask(), 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
